nibble_serial_add_ctrl: RTL and testbench

- Sequencer that time-shares one external 4-bit ripple adder slice (ports a, b, c0 -> f, c4) to perform wide additions one nibble per clock.
- Latches wide operands on a start pulse and feeds the slice least-significant nibble first, chaining the carry through a register.
- Assembles the wide sum and reports completion with a one-cycle done pulse.
- Sits between a requester (test logic or a higher-level lab datapath) and the shared 4-bit adder.

---
 rtl/nibble_serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Sequencer that time-shares one external 4-bit adder slice to perform a wide
// addition one nibble per clock, least-significant nibble first, with the carry
// chained through a register. A one-cycle done pulse marks completion.
//
// Optional feature (macro NIBBLE_SERIAL_SUB_EN): adds i_sub; when set with
// start, computes op_a - op_b (o_cout = 1 means no borrow).
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_start             request pulse, accepted only in IDLE
//   i_op_a, i_op_b      W-bit operands, latched on the accepted start edge
//   i_cin               initial carry-in, latched with start
//   i_sub               (NIBBLE_SERIAL_SUB_EN only) subtract request
//   o_busy              high while the nibble sequence runs
//   o_done              one-cycle completion pulse
//   o_sum, o_cout       result registers, held until the next accepted start
//   o_add_a/b/c0        drive to the shared slice (zero outside RUN)
//   i_add_f, i_add_c4   result from the shared slice
module nibble_serial_add_ctrl #(
   parameter int unsigned NIBBLES = 4,
   localparam int unsigned W = 4 * NIBBLES
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [W-1:0] i_op_a,
   input  logic [W-1:0] i_op_b,
   input  logic         i_cin,
`ifdef NIBBLE_SERIAL_SUB_EN
   input  logic         i_sub,
`endif
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_sum,
   output logic         o_cout,
   output logic [3:0]   o_add_a,
   output logic [3:0]   o_add_b,
   output logic         o_add_c0,
   input  logic [3:0]   i_add_f,
   input  logic         i_add_c4
);

   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          r_state;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [W-1:0]    r_sum;
   logic            r_carry;
   logic            r_cout;
   logic            r_busy;
   logic            r_done;
   logic [IdxW-1:0] r_idx;

   // Bit offset of the current nibble.
   logic [IdxW+1:0] w_base;
   logic            w_run;

   assign w_base = {r_idx, 2'b00};
   assign w_run  = (r_state == StRun);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_idx   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_a     <= i_op_a;
`ifdef NIBBLE_SERIAL_SUB_EN
                  // Subtract as A + ~B + 1; cin is ignored when subtracting.
                  r_b     <= i_sub ? ~i_op_b : i_op_b;
                  r_carry <= i_sub | i_cin;
`else
                  r_b     <= i_op_b;
                  r_carry <= i_cin;
`endif
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= StRun;
               end
            end
            StRun: begin
               r_sum[w_base +: 4] <= i_add_f;
               r_carry            <= i_add_c4;
               if (r_idx == LastIdx) begin
                  r_idx   <= '0;
                  r_cout  <= i_add_c4;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= StDone;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Slice drive is combinational from the operand registers, gated to RUN.
   assign o_add_a  = w_run ? r_a[w_base +: 4] : 4'h0;
   assign o_add_b  = w_run ? r_b[w_base +: 4] : 4'h0;
   assign o_add_c0 = w_run & r_carry;

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

   localparam int unsigned N = 4;
   localparam int unsigned W = 4 * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         busy, done, cout, add_c0;
   logic [W-1:0] sum;
   logic [3:0]   add_a, add_b, add_f;
   logic         add_c4;

   int n_vec = 0;
   int n_err = 0;

   // Expected {cout, sum} per accepted request, in issue order.
   logic [W:0] sb_q[$];

   always #5 clk = ~clk;

   // Behavioural model of the external 4-bit slice.
   logic [4:0] slice_res;
   assign slice_res = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_c0};
   assign add_f  = slice_res[3:0];
   assign add_c4 = slice_res[4];

   nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_start  (start),
      .i_op_a   (op_a),
      .i_op_b   (op_b),
      .i_cin    (cin),
`ifdef NIBBLE_SERIAL_SUB_EN
      .i_sub    (sub),
`endif
      .o_busy   (busy),
      .o_done   (done),
      .o_sum    (sum),
      .o_cout   (cout),
      .o_add_a  (add_a),
      .o_add_b  (add_b),
      .o_add_c0 (add_c0),
      .i_add_f  (add_f),
      .i_add_c4 (add_c4)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference result from plain arithmetic on whole operands.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic c, input logic s);
      longint ia = longint'(a);
      longint ib = longint'(b);
      longint m  = longint'(1) << W;
      if (s) return {(ia >= ib), W'((ia - ib + m) % m)};
      return (W + 1)'(ia + ib + longint'(c));
   endfunction

   // Carry entering nibble i, derived from the low 4*i bits of the operands.
   function automatic logic [N-1:0] carries(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input logic s);
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) begin
         longint m  = longint'(1) << (4 * i);
         longint la = longint'(a) % m;
         longint lb = longint'(b) % m;
         if (i == 0) r[i] = s ? 1'b1 : c;
         else if (s) r[i] = (la >= lb);
         else r[i] = ((la + lb + longint'(c)) >= m);
      end
      return r;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            logic [W:0] e;
            e = sb_q.pop_front();
            check("sum", 32'(sum), 32'(e[W-1:0]));
            check("cout", 32'(cout), 32'(e[W]));
         end
      end
   end

   // Issue one request and check latency, busy width and carry chain into the slice.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
      int lat;
      int nb;
      logic [N-1:0] seq;
      logic s_eff;
`ifdef NIBBLE_SERIAL_SUB_EN
      s_eff = s;
`else
      s_eff = 1'b0;
`endif
      @(negedge clk);
      op_a = a; op_b = b; cin = c; sub = s_eff; start = 1'b1;
      sb_q.push_back(model(a, b, c, s_eff));
      @(negedge clk);
      start = 1'b0;
      op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
      lat = 0; nb = 0; seq = '0;
      while (lat < 20) begin
         if (done) break;
         if (busy) begin
            nb++;
            if (lat < N) seq[lat] = add_c0;
         end
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(N));
      check("busy_cycles", 32'(nb), 32'(N));
      check("c0_chain", 32'(seq), 32'(carries(a, b, c, s_eff)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int lat;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_slice", 32'({add_a, add_b, add_c0}), 32'd0);
      rst = 1'b0;

      // Directed cases.
      run_op(16'h0000, 16'h0001, 1'b1, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("sum_hold", 32'(sum), 32'h5556);
         check("idle_slice", 32'({add_a, add_b, add_c0}), 32'd0);
      end

      // Start requests during RUN and DONE are dropped.
      @(negedge clk);
      op_a = 16'h00FF; op_b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
      sb_q.push_back(17'h00100);
      @(negedge clk);
      op_a = 16'hAAAA; op_b = 16'h5555;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("drop_done_seen", 32'(done), 32'd1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_sum", 32'(sum), 32'h0100);

      // Reset two cycles into RUN aborts without a done pulse.
      op_a = 16'h1111; op_b = 16'h2222; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      run_op(16'h000F, 16'h000F, 1'b0, 1'b0);

`ifdef NIBBLE_SERIAL_SUB_EN
      run_op(16'h0005, 16'h0007, 1'b0, 1'b1);
      run_op(16'h0009, 16'h0003, 1'b1, 1'b1);
`endif

      // Randomized requests, with idle gaps of random length.
      for (int i = 0; i < 40; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      run_op(16'h0000, 16'h0000, 1'b0, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
